// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared board-I/O timing defaults and repeat-FSM encoding
package board_io_pkg;

  localparam int CLK_HZ           = 100_000_000;
  localparam int DEBOUNCE_MS      = 10;
  localparam int REPEAT_DELAY_MS  = 500;
  localparam int REPEAT_PERIOD_MS = 100;

  localparam int CYCLES_PER_MS       = CLK_HZ / 1000;
  localparam int DEF_STABLE_CYCLES   = CYCLES_PER_MS * DEBOUNCE_MS;
  localparam int DEF_REPEAT_DELAY    = CYCLES_PER_MS * REPEAT_DELAY_MS;
  localparam int DEF_REPEAT_PERIOD   = CYCLES_PER_MS * REPEAT_PERIOD_MS;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one button channel: synchroniser, stability counter, auto-repeat FSM
module debounce_ch
  import board_io_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic rpt_en,
  output logic btn_out,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_rpt
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic [CNT_W-1:0]       cnt;
  logic [RPT_W-1:0]       rcnt;
  rpt_state_t             state;

  logic sync;
  logic mismatch;
  logic accept;
  logic rise_now;
  logic fall_now;

  // A new level is accepted on the edge that completes the stable run.
  always_comb begin
    sync     = sync_ff[SYNC_STAGES-1];
    mismatch = (sync != btn_out);
    accept   = mismatch && (cnt == CNT_LAST);
    rise_now = accept && !btn_out;
    fall_now = accept && btn_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff  <= '0;
      cnt      <= '0;
      btn_out  <= 1'b0;
      btn_rise <= 1'b0;
      btn_fall <= 1'b0;
      btn_rpt  <= 1'b0;
      rcnt     <= '0;
      state    <= RPT_IDLE;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], btn_in};

      if (!mismatch) begin
        cnt <= '0;
      end else if (accept) begin
        cnt     <= '0;
        btn_out <= ~btn_out;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      btn_rise <= rise_now;
      btn_fall <= fall_now;
      btn_rpt  <= 1'b0;

      // A release or disabled repeat abandons any pending strobe on this edge.
      if (fall_now || !rpt_en) begin
        state <= RPT_IDLE;
        rcnt  <= '0;
      end else begin
        case (state)
          RPT_IDLE: begin
            rcnt <= '0;
            if (rise_now) state <= RPT_DELAY;
          end
          RPT_DELAY: begin
            if (rcnt == DLY_LAST) begin
              btn_rpt <= 1'b1;
              rcnt    <= '0;
              state   <= RPT_REPEAT;
            end else begin
              rcnt <= rcnt + RPT_W'(1);
            end
          end
          RPT_REPEAT: begin
            if (rcnt == PER_LAST) begin
              btn_rpt <= 1'b1;
              rcnt    <= '0;
            end else begin
              rcnt <= rcnt + RPT_W'(1);
            end
          end
          default: begin
            state <= RPT_IDLE;
            rcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - N-channel push-button conditioner built from debounce_ch
module debounce_multi
  import board_io_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  input  logic            rpt_en,
  output logic [N_CH-1:0] btn_out,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_rpt
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .btn_in  (btn_in[i]),
      .rpt_en  (rpt_en),
      .btn_out (btn_out[i]),
      .btn_rise(btn_rise[i]),
      .btn_fall(btn_fall[i]),
      .btn_rpt (btn_rpt[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - vector table, directed corner cases and randomized model comparison
module tb_debounce_multi;

  localparam int NC = 4;
  localparam int SS = 2;
  localparam int SC = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          rpt_en;
  logic [NC-1:0] btn_in;
  logic [NC-1:0] btn_out, btn_rise, btn_fall, btn_rpt;

  debounce_multi #(
    .N_CH(NC), .SYNC_STAGES(SS), .STABLE_CYCLES(SC),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .rpt_en(rpt_en),
    .btn_out(btn_out), .btn_rise(btn_rise), .btn_fall(btn_fall), .btn_rpt(btn_rpt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int t      = 0;

  // Reference: input delay line, run length of disagreeing samples, press timestamp.
  bit            m_pipe [NC][SS];
  int            m_run  [NC];
  int            m_press[NC];
  bit            m_armed[NC];
  logic [NC-1:0] m_out, m_rise, m_fall, m_rpt;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at edge %0d: got %h required %h", name, t, act, exp);
  endtask

  task automatic model_step();
    bit sv;
    int d;
    t++;
    for (int c = 0; c < NC; c++) begin
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      m_rpt[c]  = 1'b0;
      if (rst) begin
        for (int k = 0; k < SS; k++) m_pipe[c][k] = 1'b0;
        m_run[c] = 0; m_out[c] = 1'b0; m_armed[c] = 1'b0;
      end else begin
        sv = m_pipe[c][SS-1];
        for (int k = SS-1; k > 0; k--) m_pipe[c][k] = m_pipe[c][k-1];
        m_pipe[c][0] = btn_in[c];
        if (sv != m_out[c]) begin
          m_run[c]++;
          if (m_run[c] == SC) begin
            m_run[c] = 0;
            m_out[c] = sv;
            if (sv) m_rise[c] = 1'b1;
            else    m_fall[c] = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
        if (m_fall[c] || !rpt_en) begin
          m_armed[c] = 1'b0;
        end else if (m_rise[c]) begin
          m_armed[c] = 1'b1;
          m_press[c] = t;
        end else if (m_armed[c]) begin
          d = t - m_press[c];
          if (d >= RD && (d - RD) % RP == 0) m_rpt[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model", {btn_out, btn_rise, btn_fall, btn_rpt}, {m_out, m_rise, m_fall, m_rpt});
  endtask

  typedef struct {
    logic          rst;
    logic [NC-1:0] btn;
    logic          en;
    int            edges;
    logic [15:0]   exp;   // {out, rise, fall, rpt}
  } vec_t;

  vec_t vt[13];
  int   hold[NC];
  int   p, t0, n;
  bit   seen;

  initial begin
    rst = 1'b1; rpt_en = 1'b0; btn_in = '0;
    m_out = '0; m_rise = '0; m_fall = '0; m_rpt = '0;
    for (int c = 0; c < NC; c++) begin
      m_run[c] = 0; m_press[c] = 0; m_armed[c] = 1'b0;
      for (int k = 0; k < SS; k++) m_pipe[c][k] = 1'b0;
    end

    vt[0]  = '{1'b1, 4'h0, 1'b0, 3, 16'h0000};
    vt[1]  = '{1'b0, 4'h1, 1'b0, 9, 16'h0000};
    vt[2]  = '{1'b0, 4'h1, 1'b0, 1, 16'h1100};
    vt[3]  = '{1'b0, 4'h1, 1'b0, 1, 16'h1000};
    vt[4]  = '{1'b0, 4'h0, 1'b0, 9, 16'h1000};
    vt[5]  = '{1'b0, 4'h0, 1'b0, 1, 16'h0010};
    vt[6]  = '{1'b0, 4'h0, 1'b0, 1, 16'h0000};
    vt[7]  = '{1'b0, 4'hF, 1'b0, 9, 16'h0000};
    vt[8]  = '{1'b0, 4'hF, 1'b0, 1, 16'hFF00};
    vt[9]  = '{1'b0, 4'hF, 1'b0, 1, 16'hF000};
    vt[10] = '{1'b0, 4'h0, 1'b0, 9, 16'hF000};
    vt[11] = '{1'b0, 4'h0, 1'b0, 1, 16'h00F0};
    vt[12] = '{1'b0, 4'h0, 1'b0, 1, 16'h0000};

    for (int i = 0; i < 13; i++) begin
      rst = vt[i].rst; btn_in = vt[i].btn; rpt_en = vt[i].en;
      repeat (vt[i].edges) tick();
      check($sformatf("vec%0d", i), {btn_out, btn_rise, btn_fall, btn_rpt}, vt[i].exp);
    end

    // Bounce on channel 1: 5 high, 1 low, 5 high, then low.
    rpt_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      btn_in = (i < 5 || (i >= 6 && i < 11)) ? 4'h2 : 4'h0;
      tick();
      check("bounce_ch1", {15'd0, btn_out[1] | btn_rise[1] | btn_rpt[1]}, 16'd0);
    end

    // Auto-repeat on channel 2, rpt_en dropped before P+27.
    btn_in = 4'h4;
    t0 = t + 1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (btn_rise[2]) begin seen = 1'b1; p = t; end
    end
    check("rpt_rise_seen", {15'd0, seen}, 16'd1);
    if (seen) begin
      check("rpt_rise_lat", 16'(p - t0), 16'd9);
      for (int d = 1; d <= 40; d++) begin
        tick();
        check($sformatf("rpt_P+%0d", d), {15'd0, btn_rpt[2]}, {15'd0, (d == 20 || d == 25)});
        if (d == 26) rpt_en = 1'b0;
      end
    end
    btn_in = 4'h0;
    repeat (12) tick();

    // Reset while channel 3 is qualifying.
    btn_in = 4'h8;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("rst_outputs", {btn_out, btn_rise, btn_fall, btn_rpt}, 16'h0000);
    tick();
    rst = 1'b0;
    t0 = t + 1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (btn_rise[3]) begin seen = 1'b1; p = t; end
    end
    check("rst_requal_seen", {15'd0, seen}, 16'd1);
    if (seen) check("rst_requal_lat", 16'(p - t0), 16'd9);

    // Randomized run against the reference.
    for (int c = 0; c < NC; c++) hold[c] = $urandom_range(1, 15);
    n = 0;
    while (n < 3000) begin
      for (int c = 0; c < NC; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          btn_in[c] = ~btn_in[c];
          hold[c]   = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 60) : $urandom_range(1, 12);
        end
      end
      if ($urandom_range(0, 63) == 0) rpt_en = ~rpt_en;
      rst = ($urandom_range(0, 499) == 0);
      tick();
      n++;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
